// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss BCD timer blocks.
package timer_pkg;

  // Timer control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Largest legal ones digit and largest legal seconds-tens digit
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Digit field offsets in the 16-bit {min_tens, min_ones, sec_tens, sec_ones} packing
  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 12;

  // Saturate a digit at the given maximum
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Synchronizes the divided clock into clk and emits a 1-cycle pulse per rising edge.
module tick_sync #(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_div_clk,
  output logic o_tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Shift div_clk through the synchronizer and keep one history bit for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_div_clk};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  // A high level that follows a low one marks exactly one tick
  assign o_tick = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer driven by ticks from the clock divider output.
module countdown_timer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_clk,
  input  logic        load,
  input  logic [15:0] load_bcd,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        done
);
  import timer_pkg::*;

  logic        w_tick;
  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_digits;
  logic [15:0] w_digits_next;
  logic [15:0] w_clamped;
  logic [15:0] w_decr;
  logic        w_done_next;
  logic        r_running;
  logic        r_expired;
  logic        r_done;

  tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .clk      (clk),
    .rst      (rst),
    .i_div_clk(div_clk),
    .o_tick   (w_tick)
  );

  // Clamp each loaded digit into its legal range
  always_comb begin
    w_clamped = '0;
    w_clamped[MIN_TENS_LSB +: 4] = clamp_digit(load_bcd[MIN_TENS_LSB +: 4], BCD_MAX);
    w_clamped[MIN_ONES_LSB +: 4] = clamp_digit(load_bcd[MIN_ONES_LSB +: 4], BCD_MAX);
    w_clamped[SEC_TENS_LSB +: 4] = clamp_digit(load_bcd[SEC_TENS_LSB +: 4], SEC_TENS_MAX);
    w_clamped[SEC_ONES_LSB +: 4] = clamp_digit(load_bcd[SEC_ONES_LSB +: 4], BCD_MAX);
  end

  // One-second BCD decrement with a borrow rippling from seconds-ones upward
  always_comb begin
    logic       w_borrow;
    logic [3:0] w_d;
    w_decr   = r_digits;
    w_borrow = 1'b0;

    w_d = r_digits[SEC_ONES_LSB +: 4];
    if (w_d == 4'd0) begin
      w_decr[SEC_ONES_LSB +: 4] = BCD_MAX;
      w_borrow = 1'b1;
    end else begin
      w_decr[SEC_ONES_LSB +: 4] = w_d - 4'd1;
    end

    w_d = r_digits[SEC_TENS_LSB +: 4];
    if (w_borrow) begin
      if (w_d == 4'd0) begin
        w_decr[SEC_TENS_LSB +: 4] = SEC_TENS_MAX;
      end else begin
        w_decr[SEC_TENS_LSB +: 4] = w_d - 4'd1;
        w_borrow = 1'b0;
      end
    end

    w_d = r_digits[MIN_ONES_LSB +: 4];
    if (w_borrow) begin
      if (w_d == 4'd0) begin
        w_decr[MIN_ONES_LSB +: 4] = BCD_MAX;
      end else begin
        w_decr[MIN_ONES_LSB +: 4] = w_d - 4'd1;
        w_borrow = 1'b0;
      end
    end

    // Minutes-tens is never zero here while a borrow is pending, because 0000 is never counted down
    w_d = r_digits[MIN_TENS_LSB +: 4];
    if (w_borrow && (w_d != 4'd0)) begin
      w_decr[MIN_TENS_LSB +: 4] = w_d - 4'd1;
    end
  end

  // Resolve load > start > pause > tick; an event not applicable in the current state falls through
  always_comb begin
    w_state_next  = r_state;
    w_digits_next = r_digits;
    w_done_next   = 1'b0;
    if (load && (r_state != RUN)) begin
      w_digits_next = w_clamped;
      w_state_next  = IDLE;
    end else if (start && ((r_state == IDLE) || (r_state == PAUSED)) && (r_digits != 16'h0000)) begin
      w_state_next = RUN;
    end else if (pause && (r_state == RUN)) begin
      w_state_next = PAUSED;
    end else if (pause && (r_state == PAUSED)) begin
      w_state_next = RUN;
    end else if (w_tick && (r_state == RUN)) begin
      w_digits_next = w_decr;
      if (r_digits == 16'h0001) begin
        w_state_next = DONE;
        w_done_next  = 1'b1;
      end
    end
  end

  // Register state, digits and the status flags derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_digits  <= 16'h0000;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_digits  <= w_digits_next;
      r_running <= (w_state_next == RUN);
      r_expired <= (w_state_next == DONE);
      r_done    <= w_done_next;
    end
  end

  assign digits  = r_digits;
  assign running = r_running;
  assign expired = r_expired;
  assign done    = r_done;

endmodule
